// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the multiplexed RTC address/data bus: periodic 9-register
// mirror scan interleaved round-robin with single writes from the controller.
module rtc_bus_sequencer #(
  parameter int T_PH        = 10,
  parameter int REFRESH_CYC = 1_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_req_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [7:0] ad_in_i,
  output logic [7:0] ad_out_o,
  output logic       ad_oe_o,
  output logic       a_d_o,
  output logic       cs_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic       wr_ack_o,
  output logic [7:0] regseg_o,
  output logic [7:0] regmin_o,
  output logic [7:0] reghora_o,
  output logic [7:0] regdate_o,
  output logic [7:0] regmes_o,
  output logic [7:0] regano_o,
  output logic [7:0] regTseg_o,
  output logic [7:0] regTmin_o,
  output logic [7:0] regThora_o,
  output logic       scan_done_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR_SET, ADDR_STB, ADDR_HLD, DATA_SET, DATA_STB, DATA_HLD, RECOVER
  } state_t;

  localparam int PH_W = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam int RC_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(T_PH - 1);
  localparam logic [PH_W-1:0] PH_PRE   = PH_W'((T_PH > 1) ? T_PH - 2 : 0);
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(REFRESH_CYC - 1);
  localparam logic [3:0]      LAST_IDX = 4'd8;

  state_t          state;
  logic [PH_W-1:0] ph_cnt;
  logic [RC_W-1:0] ref_cnt;
  logic            scan_active;
  logic            scan_pending;
  logic            last_wr;
  logic            cur_is_wr;
  logic [3:0]      scan_idx;
  logic [7:0]      cur_data;
  logic [7:0]      mirror [9];

  logic            tick;
  logic            ph_last;
  logic            pre_rec_last;
  logic            grant_wr;
  logic            grant_rd;
  logic            scan_finish;
  logic [7:0]      scan_addr;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    scan_addr = 8'h21;
    case (scan_idx)
      4'd0:    scan_addr = 8'h21;
      4'd1:    scan_addr = 8'h22;
      4'd2:    scan_addr = 8'h23;
      4'd3:    scan_addr = 8'h24;
      4'd4:    scan_addr = 8'h25;
      4'd5:    scan_addr = 8'h26;
      4'd6:    scan_addr = 8'h41;
      4'd7:    scan_addr = 8'h42;
      4'd8:    scan_addr = 8'h43;
      default: scan_addr = 8'h21;
    endcase
  end

  assign tick    = (ref_cnt == RC_LAST);
  assign ph_last = (ph_cnt == PH_LAST);
  // True on the edge that enters the final RECOVER clock, so the registered
  // completion pulses line up with that clock.
  assign pre_rec_last = (T_PH == 1) ? (state == DATA_HLD)
                                    : (state == RECOVER && ph_cnt == PH_PRE);
  // Write wins unless a scan is also waiting and the write had the last grant.
  assign grant_wr    = wr_req_i && (!scan_active || !last_wr);
  assign grant_rd    = scan_active && !grant_wr;
  assign scan_finish = (state == RECOVER) && ph_last && !cur_is_wr && (scan_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= IDLE;
      ph_cnt       <= '0;
      ref_cnt      <= '0;
      scan_active  <= 1'b0;
      scan_pending <= 1'b0;
      last_wr      <= 1'b0;
      cur_is_wr    <= 1'b0;
      scan_idx     <= '0;
      cur_data     <= '0;
      cs_o         <= 1'b1;
      rd_o         <= 1'b1;
      wr_o         <= 1'b1;
      a_d_o        <= 1'b1;
      ad_oe_o      <= 1'b0;
      ad_out_o     <= '0;
      busy_o       <= 1'b0;
      wr_ack_o     <= 1'b0;
      scan_done_o  <= 1'b0;
      // NOTE: the mirror array is nine plain flops, so it is cleared by reset like any other state.
      for (int i = 0; i < 9; i++) mirror[i] <= '0;
    end else begin
      ref_cnt     <= tick ? '0 : ref_cnt + RC_W'(1);
      wr_ack_o    <= pre_rec_last && cur_is_wr;
      scan_done_o <= pre_rec_last && !cur_is_wr && (scan_idx == LAST_IDX);

      if (scan_finish) begin
        scan_active  <= scan_pending | tick;
        scan_pending <= 1'b0;
      end else if (tick) begin
        if (scan_active) scan_pending <= 1'b1;
        else             scan_active  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            state     <= ADDR_SET;
            ph_cnt    <= '0;
            busy_o    <= 1'b1;
            cs_o      <= 1'b0;
            a_d_o     <= 1'b0;
            ad_oe_o   <= 1'b1;
            cur_is_wr <= grant_wr;
            last_wr   <= grant_wr;
            if (grant_wr) begin
              ad_out_o <= wr_addr_i;
              cur_data <= wr_data_i;
            end else begin
              ad_out_o <= scan_addr;
            end
          end
        end
        default: begin
          if (!ph_last) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end else begin
            ph_cnt <= '0;
            case (state)
              ADDR_SET: begin state <= ADDR_STB; wr_o <= 1'b0; end
              ADDR_STB: begin state <= ADDR_HLD; wr_o <= 1'b1; end
              ADDR_HLD: begin
                state   <= DATA_SET;
                a_d_o   <= 1'b1;
                ad_oe_o <= cur_is_wr;
                if (cur_is_wr) ad_out_o <= cur_data;
              end
              DATA_SET: begin
                state <= DATA_STB;
                if (cur_is_wr) wr_o <= 1'b0;
                else           rd_o <= 1'b0;
              end
              DATA_STB: begin
                state <= DATA_HLD;
                wr_o  <= 1'b1;
                rd_o  <= 1'b1;
                if (!cur_is_wr) mirror[scan_idx] <= ad_in_i;
              end
              DATA_HLD: begin
                state   <= RECOVER;
                cs_o    <= 1'b1;
                ad_oe_o <= 1'b0;
                a_d_o   <= 1'b1;
              end
              RECOVER: begin
                state  <= IDLE;
                busy_o <= 1'b0;
                if (!cur_is_wr) scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 4'd1;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign regseg_o   = mirror[0];
  assign regmin_o   = mirror[1];
  assign reghora_o  = mirror[2];
  assign regdate_o  = mirror[3];
  assign regmes_o   = mirror[4];
  assign regano_o   = mirror[5];
  assign regTseg_o  = mirror[6];
  assign regTmin_o  = mirror[7];
  assign regThora_o = mirror[8];

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: RTC register model, bus transaction
// monitor and hand-computed cycle/value expectations.
module tb_rtc_bus_sequencer;

  logic       clk     = 1'b0;
  logic       reset_i = 1'b0;
  logic       wr_req_i  = 1'b0;
  logic [7:0] wr_addr_i = 8'h00;
  logic [7:0] wr_data_i = 8'h00;
  logic [7:0] ad_in_i;
  logic [7:0] ad_out_o;
  logic       ad_oe_o, a_d_o, cs_o, rd_o, wr_o, wr_ack_o, scan_done_o, busy_o;
  logic [7:0] regseg_o, regmin_o, reghora_o, regdate_o, regmes_o, regano_o;
  logic [7:0] regTseg_o, regTmin_o, regThora_o;

  // Second instance with a short refresh period, used only for tick pending.
  logic [7:0] f_ad_out, f_m0, f_m1, f_m2, f_m3, f_m4, f_m5, f_m6, f_m7, f_m8;
  logic       f_oe, f_a_d, f_cs, f_rd, f_wr, f_ack, f_done, f_busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc;
  int done_cnt = 0;
  int ack_cnt  = 0;
  int done50_q[$];

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.T_PH(2), .REFRESH_CYC(200)) u_dut (
    .clk_i(clk), .reset_i(reset_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .ad_in_i(ad_in_i), .ad_out_o(ad_out_o), .ad_oe_o(ad_oe_o), .a_d_o(a_d_o),
    .cs_o(cs_o), .rd_o(rd_o), .wr_o(wr_o), .wr_ack_o(wr_ack_o),
    .regseg_o(regseg_o), .regmin_o(regmin_o), .reghora_o(reghora_o),
    .regdate_o(regdate_o), .regmes_o(regmes_o), .regano_o(regano_o),
    .regTseg_o(regTseg_o), .regTmin_o(regTmin_o), .regThora_o(regThora_o),
    .scan_done_o(scan_done_o), .busy_o(busy_o)
  );

  rtc_bus_sequencer #(.T_PH(2), .REFRESH_CYC(50)) u_dut50 (
    .clk_i(clk), .reset_i(reset_i),
    .wr_req_i(1'b0), .wr_addr_i(8'h00), .wr_data_i(8'h00),
    .ad_in_i(8'h00), .ad_out_o(f_ad_out), .ad_oe_o(f_oe), .a_d_o(f_a_d),
    .cs_o(f_cs), .rd_o(f_rd), .wr_o(f_wr), .wr_ack_o(f_ack),
    .regseg_o(f_m0), .regmin_o(f_m1), .reghora_o(f_m2),
    .regdate_o(f_m3), .regmes_o(f_m4), .regano_o(f_m5),
    .regTseg_o(f_m6), .regTmin_o(f_m7), .regThora_o(f_m8),
    .scan_done_o(f_done), .busy_o(f_busy)
  );

  // RTC model: register N reads back N+0x10 until it has been written.
  logic [7:0]   rtc_addr    = 8'h00;
  logic [255:0] rtc_written = '0;
  logic [7:0]   rtc_mem [256];

  assign ad_in_i = rtc_written[rtc_addr] ? rtc_mem[rtc_addr] : rtc_addr + 8'h10;

  always @(posedge clk) begin
    if (!cs_o && !a_d_o && ad_oe_o) rtc_addr <= ad_out_o;
    if (!cs_o && a_d_o && !wr_o) begin
      rtc_mem[rtc_addr]     <= ad_out_o;
      rtc_written[rtc_addr] <= 1'b1;
    end
  end

  always @(posedge clk or negedge reset_i)
    if (!reset_i) cyc <= 0;
    else          cyc <= cyc + 1;

  // Bus monitor: one record per chip-select window.
  typedef struct {
    int         start;
    logic [7:0] addr;
    logic [7:0] data;
    int         cs_len;
    int         wr_a;
    int         wr_d;
    int         rd_d;
  } bus_rec_t;

  bus_rec_t mon_q[$];
  bus_rec_t cur;
  bit       in_txn = 1'b0;

  always @(negedge clk) begin
    if (!reset_i) begin
      in_txn = 1'b0;
    end else begin
      if (!cs_o) begin
        if (!in_txn) begin
          cur = '{start: cyc, addr: 8'h00, data: 8'h00, cs_len: 0, wr_a: 0, wr_d: 0, rd_d: 0};
          in_txn = 1'b1;
        end
        cur.cs_len++;
        if (!a_d_o && ad_oe_o) cur.addr = ad_out_o;
        if (a_d_o && ad_oe_o)  cur.data = ad_out_o;
        if (!wr_o && a_d_o)    cur.wr_d++;
        if (!wr_o && !a_d_o)   cur.wr_a++;
        if (!rd_o)             cur.rd_d++;
      end else if (in_txn) begin
        mon_q.push_back(cur);
        in_txn = 1'b0;
      end
      if (scan_done_o) done_cnt++;
      if (wr_ack_o)    ack_cnt++;
      if (f_done)      done50_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 2000 && cyc != target; i++) step();
  endtask

  function automatic logic [7:0] mirror_at(input int i);
    case (i)
      0: return regseg_o;
      1: return regmin_o;
      2: return reghora_o;
      3: return regdate_o;
      4: return regmes_o;
      5: return regano_o;
      6: return regTseg_o;
      7: return regTmin_o;
      default: return regThora_o;
    endcase
  endfunction

  logic [7:0] scan_tab [9];
  logic [7:0] exp_mir  [9];

  initial begin
    scan_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    // regmin reflects the write issued before the first scan.
    exp_mir  = '{8'h31, 8'h45, 8'h33, 8'h34, 8'h35, 8'h36, 8'h51, 8'h52, 8'h53};

    // Reset values
    repeat (3) step();
    check("rst_cs", cs_o, 1);
    check("rst_rd", rd_o, 1);
    check("rst_wr", wr_o, 1);
    check("rst_a_d", a_d_o, 1);
    check("rst_oe", ad_oe_o, 0);
    check("rst_ad_out", ad_out_o, 8'h00);
    check("rst_busy", busy_o, 0);
    check("rst_ack", wr_ack_o, 0);
    check("rst_done", scan_done_o, 0);
    check("rst_regseg", regseg_o, 8'h00);
    check("rst_regThora", regThora_o, 8'h00);
    reset_i = 1'b1;

    // Single write in IDLE; address input changes after grant
    step_to(5);
    wr_req_i = 1'b1; wr_addr_i = 8'h22; wr_data_i = 8'h45;
    step();
    check("wr_busy", busy_o, 1);
    check("wr_cs_low", cs_o, 0);
    check("wr_addr_phase", a_d_o, 0);
    wr_addr_i = 8'h30;
    for (int i = 0; i < 40 && !wr_ack_o; i++) step();
    check("wr_ack_cyc", cyc, 19);
    wr_req_i = 1'b0;
    step();
    check("wr_ack_width", wr_ack_o, 0);
    check("wr_idle_busy", busy_o, 0);
    step();
    check("wr_rec_cnt", mon_q.size(), 1);
    if (mon_q.size() >= 1) begin
      check("wr_start", mon_q[0].start, 6);
      check("wr_addr", mon_q[0].addr, 8'h22);
      check("wr_data", mon_q[0].data, 8'h45);
      check("wr_cs_len", mon_q[0].cs_len, 12);
      check("wr_strobe_a", mon_q[0].wr_a, 2);
      check("wr_strobe_d", mon_q[0].wr_d, 2);
      check("wr_no_rd", mon_q[0].rd_d, 0);
    end
    check("wr_mirror_kept", regmin_o, 8'h00);

    // First scan, no writes
    mon_q.delete(); done_cnt = 0;
    for (int i = 0; i < 500 && !scan_done_o; i++) step();
    check("scan_done_cyc", cyc, 334);
    step_to(398);
    check("scan_done_cnt", done_cnt, 1);
    check("scan_rd_cnt", mon_q.size(), 9);
    for (int i = 0; i < 9 && i < mon_q.size(); i++) begin
      check($sformatf("rd%0d_addr", i), mon_q[i].addr, scan_tab[i]);
      check($sformatf("rd%0d_start", i), mon_q[i].start, 201 + 15 * i);
      check($sformatf("rd%0d_rd_len", i), mon_q[i].rd_d, 2);
      check($sformatf("rd%0d_wr_d", i), mon_q[i].wr_d, 0);
    end
    for (int i = 0; i < 9; i++) check($sformatf("mirror%0d", i), mirror_at(i), exp_mir[i]);

    // Write held through a whole scan: W, R0, W, R1, ...
    mon_q.delete(); ack_cnt = 0;
    step_to(400);
    wr_req_i = 1'b1; wr_addr_i = 8'h26; wr_data_i = 8'h77;
    for (int i = 0; i < 600 && !scan_done_o; i++) step();
    check("mix_done_cyc", cyc, 669);
    wr_req_i = 1'b0;
    check("mix_ack_cnt", ack_cnt, 9);
    check("mix_rec_cnt", mon_q.size(), 18);
    for (int i = 0; i < 18 && i < mon_q.size(); i++) begin
      if (i % 2 == 0) begin
        check($sformatf("mix%0d_wr", i), mon_q[i].wr_d, 2);
        check($sformatf("mix%0d_addr", i), mon_q[i].addr, 8'h26);
        check($sformatf("mix%0d_data", i), mon_q[i].data, 8'h77);
      end else begin
        check($sformatf("mix%0d_rd", i), mon_q[i].rd_d, 2);
        check($sformatf("mix%0d_addr", i), mon_q[i].addr, scan_tab[i / 2]);
      end
    end
    check("mix_regano", regano_o, 8'h77);
    check("mix_regmin", regmin_o, 8'h45);

    // Asynchronous reset during DATA_STB of the pending scan's first read
    mon_q.delete();
    for (int i = 0; i < 60 && rd_o; i++) step();
    check("arst_rd_cyc", cyc, 679);
    #1 reset_i = 1'b0;
    #1;
    check("arst_cs", cs_o, 1);
    check("arst_rd", rd_o, 1);
    check("arst_a_d", a_d_o, 1);
    check("arst_oe", ad_oe_o, 0);
    check("arst_ad_out", ad_out_o, 8'h00);
    check("arst_busy", busy_o, 0);
    check("arst_regseg", regseg_o, 8'h00);
    check("arst_regano", regano_o, 8'h00);
    repeat (2) step();
    reset_i = 1'b1;
    mon_q.delete(); done50_q.delete(); done_cnt = 0;
    step_to(470);
    check("post_rst_rec", mon_q.size() >= 1, 1);
    if (mon_q.size() >= 1) begin
      check("post_rst_addr", mon_q[0].addr, 8'h21);
      check("post_rst_start", mon_q[0].start, 201);
    end
    check("post_rst_regseg", regseg_o, 8'h31);
    check("post_rst_done", done_cnt, 1);

    // Short refresh period: one pending scan runs back-to-back
    check("pend_done_cnt", done50_q.size(), 3);
    if (done50_q.size() >= 3) begin
      check("pend_first", done50_q[0], 184);
      check("pend_gap1", done50_q[1] - done50_q[0], 135);
      check("pend_gap2", done50_q[2] - done50_q[1], 135);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
